rice_stream_writer: RTL and testbench

//  Serialises Rice-coded FLAC residuals into a 1-bit stream for one subframe; the encoder counterpart of the

---
 rtl/rice_stream_writer.sv | 160 ++++++++++++++++
 tb/tb_rice_stream_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rice_stream_writer.sv
// Rice residual serialiser: emits a Rice parameter nibble per partition, then for each sample
// the unary quotient, a terminating '1', and the low `param` bits of the remainder.
module rice_stream_writer #(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 4
) (
    input  logic               iClock,
    input  logic               iReset_n,
    input  logic               iStart,
    input  logic [DATA_W-1:0]  iBlockSize,
    input  logic [3:0]         iPredictorOrder,
    input  logic [3:0]         iPartitionOrder,
    input  logic               iValid,
    input  logic [DATA_W-1:0]  iMSB,
    input  logic [DATA_W-1:0]  iLSB,
    input  logic [PARAM_W-1:0] iRiceParam,
    output logic               oReady,
    input  logic               iEnable,
    output logic               oData,
    output logic               oValid,
    output logic               oDone
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_PARAM, S_UNARY, S_STOP, S_REM, S_DONE
    } state_t;

    state_t              r_state, w_next_state;
    logic [DATA_W-1:0]   r_block_size;
    logic [3:0]          r_order;
    logic [DATA_W-1:0]   r_part_n;
    logic [DATA_W-1:0]   r_sample_cnt;
    logic [DATA_W-1:0]   r_part_cnt;
    logic                r_first_in_part;
    logic                r_done;
    logic [DATA_W-1:0]   r_msb;
    logic [DATA_W-1:0]   r_lsb;
    logic [PARAM_W-1:0]  r_param;
    logic [PARAM_W-1:0]  r_bit_idx;

    logic                w_eos;
    logic                w_sample_last;
    logic                w_part_last;
    logic [DATA_W-1:0]   w_last_part;
    logic [DATA_W-1:0]   w_first_n;

    assign w_last_part   = (DATA_W'(1) << r_order) - DATA_W'(1);
    assign w_first_n     = (iBlockSize >> iPartitionOrder) - DATA_W'(iPredictorOrder);
    assign w_sample_last = (r_sample_cnt == r_part_n - DATA_W'(1));
    assign w_part_last   = (r_part_cnt == w_last_part);
    assign oDone         = r_done;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_next_state = r_state;
        oReady       = 1'b0;
        oValid       = 1'b0;
        oData        = 1'b0;
        w_eos        = 1'b0;
        case (r_state)
            S_WAIT: begin
                oReady = 1'b1;
                if (iValid) begin
                    if (r_first_in_part) w_next_state = S_PARAM;
                    else if (iMSB != '0) w_next_state = S_UNARY;
                    else                 w_next_state = S_STOP;
                end
            end
            S_PARAM: begin
                oValid = 1'b1;
                oData  = r_param[r_bit_idx];
                if (iEnable && r_bit_idx == '0)
                    w_next_state = (r_msb != '0) ? S_UNARY : S_STOP;
            end
            S_UNARY: begin
                oValid = 1'b1;
                if (iEnable && r_msb == DATA_W'(1)) w_next_state = S_STOP;
            end
            S_STOP: begin
                oValid = 1'b1;
                oData  = 1'b1;
                if (iEnable) begin
                    if (r_param != '0) w_next_state = S_REM;
                    else               w_eos = 1'b1;
                end
            end
            S_REM: begin
                oValid = 1'b1;
                oData  = r_lsb[r_bit_idx];
                if (iEnable && r_bit_idx == '0) w_eos = 1'b1;
            end
            default: ;
        endcase
        if (w_eos) w_next_state = (w_sample_last && w_part_last) ? S_DONE : S_WAIT;
        // A restart wins over any consume happening on the same edge.
        if (iStart) w_next_state = S_WAIT;
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_block_size    <= '0;
            r_order         <= '0;
            r_part_n        <= '0;
            r_sample_cnt    <= '0;
            r_part_cnt      <= '0;
            r_first_in_part <= 1'b0;
            r_done          <= 1'b0;
            r_msb           <= '0;
            r_lsb           <= '0;
            r_param         <= '0;
            r_bit_idx       <= '0;
        end else if (iStart) begin
            r_block_size    <= iBlockSize;
            r_order         <= iPartitionOrder;
            r_part_n        <= w_first_n;
            r_sample_cnt    <= '0;
            r_part_cnt      <= '0;
            r_first_in_part <= 1'b1;
            r_done          <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: if (iValid) begin
                    r_msb     <= iMSB;
                    r_lsb     <= iLSB;
                    r_bit_idx <= PARAM_W'(PARAM_W - 1);
                    if (r_first_in_part) r_param <= iRiceParam;
                end
                S_PARAM: if (iEnable) begin
                    if (r_bit_idx == '0) r_first_in_part <= 1'b0;
                    else                 r_bit_idx <= r_bit_idx - PARAM_W'(1);
                end
                S_UNARY: if (iEnable) r_msb <= r_msb - DATA_W'(1);
                S_STOP:  if (iEnable) r_bit_idx <= r_param - PARAM_W'(1);
                S_REM:   if (iEnable) r_bit_idx <= r_bit_idx - PARAM_W'(1);
                default: ;
            endcase
            if (w_eos) begin
                if (!w_sample_last) begin
                    r_sample_cnt <= r_sample_cnt + DATA_W'(1);
                end else if (!w_part_last) begin
                    r_part_cnt      <= r_part_cnt + DATA_W'(1);
                    r_sample_cnt    <= '0;
                    r_part_n        <= r_block_size >> r_order;
                    r_first_in_part <= 1'b1;
                end else begin
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rice_stream_writer.sv
// Directed bench for rice_stream_writer: a table of single-sample residuals plus hand-written
// sequences for multi-sample, multi-partition, stall, restart and reset cases.
module tb_rice_stream_writer;

    logic        iClock = 1'b0;
    logic        iReset_n = 1'b0;
    logic        iStart = 1'b0;
    logic [15:0] iBlockSize = '0;
    logic [3:0]  iPredictorOrder = '0;
    logic [3:0]  iPartitionOrder = '0;
    logic        iValid = 1'b0;
    logic [15:0] iMSB = '0;
    logic [15:0] iLSB = '0;
    logic [3:0]  iRiceParam = '0;
    logic        oReady;
    logic        iEnable = 1'b0;
    logic        oData;
    logic        oValid;
    logic        oDone;

    rice_stream_writer #(.DATA_W(16), .PARAM_W(4)) dut (
        .iClock(iClock), .iReset_n(iReset_n), .iStart(iStart),
        .iBlockSize(iBlockSize), .iPredictorOrder(iPredictorOrder),
        .iPartitionOrder(iPartitionOrder), .iValid(iValid), .iMSB(iMSB), .iLSB(iLSB),
        .iRiceParam(iRiceParam), .oReady(oReady), .iEnable(iEnable), .oData(oData),
        .oValid(oValid), .oDone(oDone)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic [3:0]  param;
        logic [15:0] msb;
        logic [15:0] lsb;
        bit          rand_en;
        logic [63:0] exp_bits;
        int          exp_len;
    } vec_t;

    vec_t        vecs[7];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          q_n;
    logic [15:0] q_msb[16];
    logic [15:0] q_lsb[16];
    logic [3:0]  q_par[16];
    logic [255:0] bits;
    int          len;
    bit          timed_out;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_cfg(input logic [15:0] bs, input logic [3:0] pred, input logic [3:0] ord);
        iStart = 1'b1;
        iBlockSize = bs;
        iPredictorOrder = pred;
        iPartitionOrder = ord;
        iValid = 1'b0;
        @(negedge iClock);
        iStart = 1'b0;
    endtask

    // Feeds q_* samples whenever oReady and records consumed bits; stops on oDone or stop_len bits.
    task automatic run(input bit rand_en, input int stop_len, output logic [255:0] b,
                       output int n, output bit to);
        int idx = 0;
        b = '0;
        n = 0;
        to = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (oDone || (stop_len != 0 && n == stop_len)) begin
                to = 1'b0;
                break;
            end
            iEnable = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (oReady && idx < q_n) begin
                iValid = 1'b1;
                iMSB = q_msb[idx];
                iLSB = q_lsb[idx];
                iRiceParam = q_par[idx];
            end else begin
                iValid = 1'b0;
            end
            if (oValid && iEnable) begin
                b = {b[254:0], oData};
                n++;
            end
            if (oReady && iValid) idx++;
            @(negedge iClock);
        end
        iValid = 1'b0;
        iEnable = 1'b0;
    endtask

    task automatic check_run(input string name, input logic [255:0] exp_b, input int exp_n);
        check({name, " timeout"}, 256'(timed_out), 256'(0));
        check({name, " length"}, 256'(len), 256'(exp_n));
        check({name, " bits"}, bits, exp_b);
    endtask

    initial begin
        vecs[0] = '{4'd2,  16'd1,    16'd3,    1'b0, 64'b0010_0_1_11, 8};
        vecs[1] = '{4'd0,  16'd0,    16'hFFFF, 1'b0, 64'b0000_1, 5};
        vecs[2] = '{4'd5,  16'd5,    16'h001F, 1'b1, 64'b0101_00000_1_11111, 15};
        vecs[3] = '{4'd15, 16'd0,    16'h8001, 1'b0, 64'b1111_1_000000000000001, 20};
        vecs[4] = '{4'd1,  16'd3,    16'hFFFE, 1'b0, 64'b0001_000_1_0, 9};
        vecs[5] = '{4'd3,  16'd0,    16'hFFF5, 1'b0, 64'b0011_1_101, 8};
        vecs[6] = '{4'd8,  16'd2,    16'h00A5, 1'b1, 64'b1000_00_1_10100101, 15};

        repeat (2) @(negedge iClock);
        check("reset outputs", 256'({oReady, oValid, oData, oDone}), 256'(0));
        iReset_n = 1'b1;
        @(negedge iClock);
        check("idle outputs", 256'({oReady, oValid, oData, oDone}), 256'(0));

        // Single-sample residuals: blocksize 2, predictor order 1, one partition of one sample.
        for (int v = 0; v < 7; v++) begin
            q_n = 1;
            q_msb[0] = vecs[v].msb;
            q_lsb[0] = vecs[v].lsb;
            q_par[0] = vecs[v].param;
            start_cfg(16'd2, 4'd1, 4'd0);
            run(vecs[v].rand_en, 0, bits, len, timed_out);
            check_run($sformatf("vec%0d", v), 256'(vecs[v].exp_bits), vecs[v].exp_len);
        end

        // Six samples, param 2: first sample MSB=1 LSB=3, remaining MSB=0 LSB=0.
        q_n = 6;
        for (int i = 0; i < 6; i++) begin
            q_msb[i] = (i == 0) ? 16'd1 : 16'd0;
            q_lsb[i] = (i == 0) ? 16'd3 : 16'd0;
            q_par[i] = (i == 0) ? 4'd2 : 4'd9;
        end
        start_cfg(16'd8, 4'd2, 4'd0);
        run(1'b0, 0, bits, len, timed_out);
        check_run("six samples p2", 256'(23'b0010_0111_100_100_100_100_100), 23);
        check("six samples done", 256'(oDone), 256'(1));

        // param 0, MSB 0: one '1' per sample.
        for (int i = 0; i < 6; i++) begin
            q_msb[i] = 16'd0;
            q_lsb[i] = 16'd0;
            q_par[i] = 4'd0;
        end
        start_cfg(16'd8, 4'd2, 4'd0);
        run(1'b0, 0, bits, len, timed_out);
        check_run("param0", 256'(10'b0000111111), 10);

        // Four partitions of 3,4,4,4 samples with params 1,2,3,0; other iRiceParam values are junk.
        q_n = 15;
        for (int i = 0; i < 15; i++) begin
            q_msb[i] = 16'd0;
            q_lsb[i] = 16'd0;
            q_par[i] = 4'd15;
        end
        q_par[0] = 4'd1;
        q_par[3] = 4'd2;
        q_par[7] = 4'd3;
        q_par[11] = 4'd0;
        start_cfg(16'd16, 4'd1, 4'd2);
        run(1'b0, 0, bits, len, timed_out);
        check_run("partitions", 256'({4'b0001, 6'b101010, 4'b0010, 12'b100100100100,
                                      4'b0011, 16'b1000100010001000, 4'b0000, 4'b1111}), 54);

        // Restart in the middle of the remainder bits.
        q_n = 1;
        q_msb[0] = 16'd0;
        q_lsb[0] = 16'h001F;
        q_par[0] = 4'd5;
        start_cfg(16'd2, 4'd1, 4'd0);
        run(1'b0, 5, bits, len, timed_out);
        check("pre-restart in rem", 256'({timed_out, oValid, oData}), 256'(3'b011));
        iEnable = 1'b1;
        start_cfg(16'd2, 4'd1, 4'd0);
        iEnable = 1'b0;
        check("restart wait state", 256'({oReady, oValid, oDone}), 256'(3'b100));
        q_msb[0] = 16'd1;
        q_lsb[0] = 16'd2;
        q_par[0] = 4'd3;
        run(1'b0, 0, bits, len, timed_out);
        check_run("after restart", 256'(9'b0011_0_1_010), 9);

        // Asynchronous reset in the middle of the unary run.
        q_msb[0] = 16'd5;
        q_lsb[0] = 16'd0;
        q_par[0] = 4'd2;
        start_cfg(16'd2, 4'd1, 4'd0);
        run(1'b0, 6, bits, len, timed_out);
        check("pre-reset unary", 256'({timed_out, oValid, oData}), 256'(3'b010));
        #2 iReset_n = 1'b0;
        #1 check("async reset outputs", 256'({oReady, oValid, oData, oDone}), 256'(0));
        @(negedge iClock);
        iReset_n = 1'b1;
        iValid = 1'b1;
        iEnable = 1'b1;
        repeat (3) @(negedge iClock);
        check("idle after reset", 256'({oReady, oValid, oData, oDone}), 256'(0));
        iValid = 1'b0;
        iEnable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
